data_memory_ctrl: RTL and testbench

Backing data memory directly downstream of the data cache. Serves 256-bit cache-line read and write requests over the enable/write/ack handshake that the cache miss controller drives. Each request completes after a fixed, parameterised access latency, which models main-memory delay so that cache stall behaviour is exercised. One request is in flight at a time.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/data_memory_ctrl_if.sv | 25 ++
 rtl/dmem_array.sv | 25 ++
 rtl/data_memory_ctrl.sv | 106 ++++++++++
 tb/tb_data_memory_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the cache-line backing memory.
package dmem_pkg;

  localparam int DMEM_LINE_W = 256;
  localparam int OFFSET_W    = 5;
  localparam int IDX_LSB     = OFFSET_W;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_ACK  = 2'd2;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/ack bus between the cache miss controller (master) and the backing memory (slave).
interface data_memory_ctrl_if
  import dmem_pkg::*;
#(
  parameter int LINE_W = DMEM_LINE_W
);

  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous line RAM; the read port is always registered.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int LINE_W = DMEM_LINE_W,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Backing data memory: serves one cache-line read/write at a time with a fixed
// access latency, then pulses ack_o for one cycle.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_W  = DMEM_LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int IDX_W   = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_memory_ctrl_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] dout_q, dout_d;
  logic              ram_we;
  logic [LINE_W-1:0] ram_rdata;

  // Offset bits and address bits above the index never select a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:IDX_LSB+IDX_W], bus.addr_i[IDX_LSB-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    dout_d  = dout_q;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable_i) begin
          idx_d   = bus.addr_i[IDX_LSB +: IDX_W];
          wdata_d = bus.data_i;
          wr_d    = bus.write_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // The RAM read port captures the line on this same edge.
          ram_we  = wr_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (!wr_q) begin
          dout_d = ram_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
    end
  end

  dmem_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .idx   (idx_q),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.ack_o  = ack_q;
  assign bus.data_o = dout_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every cycle
// against a line-array model with a fixed accept-to-ack distance.
module tb_data_memory_ctrl;

  localparam int LINE_W  = 256;
  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;
  localparam int IDX_W   = 9;
  localparam int ACK_LAT = LATENCY + 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  data_memory_ctrl_if #(.LINE_W(LINE_W)) bus ();

  data_memory_ctrl #(
    .LINE_W  (LINE_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int vectors = 0;
  int miscompares = 0;

  int                ack_cyc = -1;
  bit                pend_wr;
  int                pend_idx;
  logic [LINE_W-1:0] pend_data;
  logic [LINE_W-1:0] mdl_dout = '0;
  logic [LINE_W-1:0] mdl_mem [DEPTH];
  bit                written [DEPTH];
  bit                chk_on = 1'b0;

  task automatic chk(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 5) % DEPTH);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Per-cycle compare: the model completes a request exactly ACK_LAT edges after acceptance.
  always @(negedge clk_i) begin
    if (chk_on && !rst_i) begin
      if (cyc == ack_cyc) begin
        if (pend_wr) mdl_mem[pend_idx] = pend_data;
        else         mdl_dout = mdl_mem[pend_idx];
      end
      chk("ack_o", LINE_W'(bus.ack_o), LINE_W'(cyc == ack_cyc));
      chk("data_o", bus.data_o, mdl_dout);
    end
  end

  // Called at a negedge while the DUT can accept; returns at the negedge of the ack cycle.
  task automatic req(input logic [31:0] addr, input logic [LINE_W-1:0] data, input bit wr,
                     input bit scramble, output int lat, output int ackc);
    int acc;
    bus.addr_i   = addr;
    bus.data_i   = data;
    bus.write_i  = wr;
    bus.enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    acc       = cyc;
    ack_cyc   = acc + ACK_LAT;
    ackc      = ack_cyc;
    pend_wr   = wr;
    pend_idx  = idx_of(addr);
    pend_data = data;
    if (wr) written[pend_idx] = 1'b1;
    lat = -1;
    @(negedge clk_i);
    bus.enable_i = 1'b0;
    while (cyc < ackc) begin
      if (bus.ack_o && lat < 0) lat = cyc - acc;
      if (scramble) begin
        bus.addr_i   = $urandom;
        bus.data_i   = rand_line();
        bus.write_i  = ~wr;
        bus.enable_i = 1'($urandom);
      end
      @(negedge clk_i);
    end
    if (bus.ack_o && lat < 0) lat = cyc - acc;
    bus.enable_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_12, d, v_old, v_new;
    int lat, ack1, ack2;
    logic [31:0] a;
    bit wr;

    pat_a5 = {32{8'hA5}};
    pat_12 = {4{64'h1234_5678_90AB_CDEF}};
    bus.addr_i = '0; bus.data_i = '0; bus.enable_i = 1'b0; bus.write_i = 1'b0;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk_on = 1'b1;
    chk("reset_ack", LINE_W'(bus.ack_o), '0);
    chk("reset_data", bus.data_o, '0);
    @(negedge clk_i);

    // Preload line 5, then read it back with the latency measured.
    req(32'h0000_00A0, pat_a5, 1'b1, 1'b0, lat, ack1);
    chk("wr_latency", LINE_W'(lat), LINE_W'(11));
    @(negedge clk_i);
    req(32'h0000_00A0, '0, 1'b0, 1'b0, lat, ack1);
    chk("rd_latency", LINE_W'(lat), LINE_W'(11));
    chk("rd_line5", bus.data_o, pat_a5);
    @(negedge clk_i);
    chk("ack_one_cycle", LINE_W'(bus.ack_o), '0);
    chk("rd_line5_held", bus.data_o, pat_a5);

    // Write line 32, then read it.
    req(32'h0000_0400, pat_12, 1'b1, 1'b0, lat, ack1);
    chk("wr32_ack_data_unchanged", bus.data_o, pat_a5);
    @(negedge clk_i);
    req(32'h0000_0400, '0, 1'b0, 1'b0, lat, ack1);
    chk("rd_line32", bus.data_o, pat_12);

    // Back-to-back write-back then read with enable held high.
    d = rand_line();
    req(32'h0000_00E0, d, 1'b1, 1'b0, lat, ack1);
    req(32'h0000_00E0, '0, 1'b0, 1'b0, lat, ack2);
    chk("b2b_ack_gap", LINE_W'(ack2 - ack1), LINE_W'(LATENCY + 2));
    chk("b2b_rd_latency", LINE_W'(lat), LINE_W'(11));
    chk("b2b_rd_data", bus.data_o, d);

    // Inputs scrambled throughout WAIT must not disturb the latched request.
    d = rand_line();
    @(negedge clk_i);
    req(32'h0000_0120, d, 1'b1, 1'b1, lat, ack1);
    @(negedge clk_i);
    req(32'h0000_0120, '0, 1'b0, 1'b1, lat, ack1);
    chk("iso_latency", LINE_W'(lat), LINE_W'(11));
    chk("iso_data", bus.data_o, d);

    // Aliasing: line 513 maps to line 1, low offset bits ignored.
    d = rand_line();
    @(negedge clk_i);
    req(32'h0000_0020, d, 1'b1, 1'b0, lat, ack1);
    @(negedge clk_i);
    req(32'h0000_403F, '0, 1'b0, 1'b0, lat, ack1);
    chk("alias_data", bus.data_o, d);

    // Reset mid-WAIT aborts the write to line 3.
    v_old = rand_line();
    v_new = ~v_old;
    @(negedge clk_i);
    req(32'h0000_0060, v_old, 1'b1, 1'b0, lat, ack1);
    @(negedge clk_i);
    bus.addr_i = 32'h0000_0060; bus.data_i = v_new; bus.write_i = 1'b1; bus.enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.enable_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_ack", LINE_W'(bus.ack_o), '0);
    chk("rst_async_data", bus.data_o, '0);
    ack_cyc  = -1;
    mdl_dout = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    req(32'h0000_0060, '0, 1'b0, 1'b0, lat, ack1);
    chk("rst_abort_line3", bus.data_o, v_old);

    // Randomized traffic over a small line pool so reads hit written lines.
    for (int t = 0; t < 200; t++) begin
      int line;
      line = int'($urandom_range(0, 15));
      a    = ($urandom & 32'hFFFF_C000) | (32'(line) << 5) | ($urandom & 32'h1F);
      wr   = written[line] ? 1'($urandom) : 1'b1;
      d    = rand_line();
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      req(a, d, wr, 1'($urandom), lat, ack1);
      chk("rand_latency", LINE_W'(lat), LINE_W'(11));
    end

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
